seq_alu: RTL and testbench

SEQ_ALU -- requirements
Module: seq_alu

---
 rtl/seq_alu_pkg.sv | 40 ++++
 rtl/seq_alu_if.sv | 24 ++
 rtl/seq_alu_muldiv.sv | 72 +++++++
 rtl/seq_alu.sv | 153 +++++++++++++++
 tb/tb_seq_alu.sv | 173 +++++++++++++++++
 5 files changed

// File: rtl/seq_alu_pkg.sv
// Shared definitions for the sequential ALU and the control unit that drives it:
// opcodes, flag bit positions and FSM state encodings.
package seq_alu_pkg;

    localparam logic [4:0] OP_ADD = 5'd11;
    localparam logic [4:0] OP_SUB = 5'd12;
    localparam logic [4:0] OP_LSR = 5'd13;
    localparam logic [4:0] OP_LSL = 5'd14;
    localparam logic [4:0] OP_RSR = 5'd15;
    localparam logic [4:0] OP_RSL = 5'd16;
    localparam logic [4:0] OP_MOV = 5'd17;
    localparam logic [4:0] OP_MUL = 5'd18;
    localparam logic [4:0] OP_DIV = 5'd19;
    localparam logic [4:0] OP_MOD = 5'd20;
    localparam logic [4:0] OP_AND = 5'd21;
    localparam logic [4:0] OP_OR  = 5'd22;
    localparam logic [4:0] OP_XOR = 5'd23;
    localparam logic [4:0] OP_NOT = 5'd24;
    localparam logic [4:0] OP_CMP = 5'd25;
    localparam logic [4:0] OP_TST = 5'd26;
    localparam logic [4:0] OP_INC = 5'd27;
    localparam logic [4:0] OP_DEC = 5'd28;

    localparam int ZF = 3;
    localparam int NF = 2;
    localparam int CF = 1;
    localparam int VF = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_ITER = 2'd2,
        ST_DONE = 2'd3
    } alu_state_t;

    function automatic logic is_iter_op(input logic [4:0] op);
        return (op == OP_MUL) || (op == OP_DIV) || (op == OP_MOD);
    endfunction

endpackage

// File: rtl/seq_alu_if.sv
// Control-unit <-> ALU handshake: level start held until the one-cycle done pulse.
interface seq_alu_if #(
    parameter int OP_W   = 6,
    parameter int DATA_W = 16
);
    logic              alu_start;
    logic [OP_W-1:0]   alu_operation;
    logic [DATA_W-1:0] op1;
    logic [DATA_W-1:0] op2;
    logic [DATA_W-1:0] alu_result;
    logic [3:0]        alu_flags;
    logic              alu_done;
    logic              alu_busy;

    modport master (
        output alu_start, alu_operation, op1, op2,
        input  alu_result, alu_flags, alu_done, alu_busy
    );

    modport slave (
        input  alu_start, alu_operation, op1, op2,
        output alu_result, alu_flags, alu_done, alu_busy
    );
endinterface

// File: rtl/seq_alu_muldiv.sv
// Iterative shift-add multiplier and restoring divider, one bit per cycle.
// A start pulse loads the operands; last flags the cycle whose edge retires the final iteration.
module seq_alu_muldiv #(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              is_div,
    input  logic              is_mod,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic              last,
    output logic [DATA_W-1:0] res,
    output logic              c_out
);
    localparam logic [4:0] LAST_CNT = 5'(DATA_W - 1);

    logic                busy_q, div_q, mod_q;
    logic [4:0]          cnt_q;
    logic [2*DATA_W-1:0] p_q, p_d;
    logic [DATA_W-1:0]   m_q, r_q, r_d, q_q, q_d, diff;
    logic [DATA_W:0]     add_s, r_sh;
    logic                ge;

    // Product: {hi, multiplier} shifts right; divider: remainder takes the dividend MSB each step.
    always_comb begin
        add_s = {1'b0, p_q[2*DATA_W-1:DATA_W]} + (p_q[0] ? {1'b0, m_q} : '0);
        p_d   = {add_s, p_q[DATA_W-1:1]};
        r_sh  = {r_q, q_q[DATA_W-1]};
        ge    = (r_sh >= {1'b0, m_q});
        diff  = r_sh[DATA_W-1:0] - m_q;
        r_d   = ge ? diff : r_sh[DATA_W-1:0];
        q_d   = {q_q[DATA_W-2:0], ge};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy_q <= 1'b0;
            div_q  <= 1'b0;
            mod_q  <= 1'b0;
            cnt_q  <= '0;
            p_q    <= '0;
            m_q    <= '0;
            r_q    <= '0;
            q_q    <= '0;
        end else if (start) begin
            busy_q <= 1'b1;
            div_q  <= is_div;
            mod_q  <= is_mod;
            cnt_q  <= '0;
            p_q    <= {{DATA_W{1'b0}}, b};
            m_q    <= is_div ? b : a;
            r_q    <= '0;
            q_q    <= a;
        end else if (busy_q) begin
            cnt_q <= cnt_q + 5'd1;
            if (div_q) begin
                r_q <= r_d;
                q_q <= q_d;
            end else begin
                p_q <= p_d;
            end
            if (last) busy_q <= 1'b0;
        end
    end

    assign last  = busy_q && (cnt_q == LAST_CNT);
    assign res   = !div_q ? p_d[DATA_W-1:0] : (mod_q ? r_d : q_d);
    assign c_out = !div_q && (p_d[2*DATA_W-1:DATA_W] != '0);

endmodule

// File: rtl/seq_alu.sv
// Sequential ALU: single-cycle ops retire from EXEC, MUL/DIV/MOD iterate in the muldiv unit.
// state | meaning
// IDLE  | waiting for alu_start (ignored until reset release is synchronised)
// EXEC  | operands latched; single-cycle result computed, or muldiv kicked off
// ITER  | muldiv iterating, 16 cycles
// DONE  | alu_done pulse; result/flags stable
module seq_alu #(
    parameter int OP_W   = 6,
    parameter int DATA_W = 16
) (
    input logic   clk,
    input logic   reset,
    seq_alu_if.slave bus
);
    import seq_alu_pkg::*;

    localparam int              MSB = DATA_W - 1;
    localparam logic [4:0]      DW5 = 5'(DATA_W);
    localparam logic [DATA_W-1:0] ONE = {{(DATA_W-1){1'b0}}, 1'b1};

    alu_state_t        state_q, state_d;
    logic [1:0]        rst_sync_q;
    logic              accept, md_start, md_last, md_c, wr_res, c_c, v_c, sum_v, add_ci;
    logic [4:0]        op_q;
    logic [3:0]        amt;
    logic [DATA_W-1:0] a_q, b_q, result_q, res_c, md_res, add_y, rot_r, rot_l;
    logic [DATA_W:0]   sum, sh_l, sh_r;
    logic [3:0]        flags_q, flags_c, flags_md;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) rst_sync_q <= 2'b00;
        else        rst_sync_q <= {rst_sync_q[0], 1'b1};
    end

    assign accept = (state_q == ST_IDLE) && bus.alu_start && rst_sync_q[1];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept) state_d = ST_EXEC;
            ST_EXEC: state_d = is_iter_op(op_q) ? ST_ITER : ST_DONE;
            ST_ITER: if (md_last) state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.alu_done = (state_q == ST_DONE);
        bus.alu_busy = (state_q != ST_IDLE);
        md_start     = (state_q == ST_EXEC) && is_iter_op(op_q);
    end

    // Subtraction forms reuse the adder as a + ~b + 1 so C reads as "no borrow".
    always_comb begin
        add_y  = b_q;
        add_ci = 1'b0;
        case (op_q)
            OP_SUB, OP_CMP: begin add_y = ~b_q; add_ci = 1'b1; end
            OP_INC:         add_y = ONE;
            OP_DEC:         begin add_y = ~ONE; add_ci = 1'b1; end
            default: ;
        endcase
        sum   = {1'b0, a_q} + {1'b0, add_y} + {{DATA_W{1'b0}}, add_ci};
        sum_v = (a_q[MSB] == add_y[MSB]) && (sum[MSB] != a_q[MSB]);
        amt   = b_q[3:0];
        sh_l  = {1'b0, a_q} << amt;
        sh_r  = {a_q, 1'b0} >> amt;
        rot_r = (a_q >> amt) | (a_q << (DW5 - {1'b0, amt}));
        rot_l = (a_q << amt) | (a_q >> (DW5 - {1'b0, amt}));
    end

    always_comb begin
        res_c  = '0;
        c_c    = 1'b0;
        v_c    = 1'b0;
        wr_res = 1'b1;
        case (op_q)
            OP_ADD, OP_SUB, OP_INC, OP_DEC: begin
                res_c = sum[DATA_W-1:0]; c_c = sum[DATA_W]; v_c = sum_v;
            end
            OP_CMP: begin
                res_c = sum[DATA_W-1:0]; c_c = sum[DATA_W]; v_c = sum_v; wr_res = 1'b0;
            end
            OP_LSR: begin res_c = sh_r[DATA_W:1];   c_c = sh_r[0];      end
            OP_LSL: begin res_c = sh_l[DATA_W-1:0]; c_c = sh_l[DATA_W]; end
            OP_RSR: begin res_c = rot_r; c_c = (amt != 4'd0) && rot_r[MSB]; end
            OP_RSL: begin res_c = rot_l; c_c = (amt != 4'd0) && rot_l[0];   end
            OP_MOV: res_c = b_q;
            OP_AND: res_c = a_q & b_q;
            OP_OR:  res_c = a_q | b_q;
            OP_XOR: res_c = a_q ^ b_q;
            OP_NOT: res_c = ~a_q;
            OP_TST: begin res_c = a_q & b_q; wr_res = 1'b0; end
            default: res_c = '0;
        endcase
        flags_c       = '0;
        flags_c[ZF]   = (res_c == '0);
        flags_c[NF]   = res_c[MSB];
        flags_c[CF]   = c_c;
        flags_c[VF]   = v_c;
        flags_md      = '0;
        flags_md[ZF]  = (md_res == '0);
        flags_md[NF]  = md_res[MSB];
        flags_md[CF]  = md_c;
        flags_md[VF]  = (op_q != OP_MUL) && (b_q == '0);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            flags_q  <= '0;
        end else begin
            if (accept) begin
                op_q <= bus.alu_operation[4:0];
                a_q  <= bus.op1;
                b_q  <= bus.op2;
            end
            if ((state_q == ST_EXEC) && !is_iter_op(op_q)) begin
                if (wr_res) result_q <= res_c;
                flags_q <= flags_c;
            end else if ((state_q == ST_ITER) && md_last) begin
                result_q <= md_res;
                flags_q  <= flags_md;
            end
        end
    end

    assign bus.alu_result = result_q;
    assign bus.alu_flags  = flags_q;

    seq_alu_muldiv #(.DATA_W(DATA_W)) u_muldiv (
        .clk    (clk),
        .reset  (reset),
        .start  (md_start),
        .is_div (op_q != OP_MUL),
        .is_mod (op_q == OP_MOD),
        .a      (a_q),
        .b      (b_q),
        .last   (md_last),
        .res    (md_res),
        .c_out  (md_c)
    );

endmodule

// File: tb/tb_seq_alu.sv
// Directed plus random checks of seq_alu against an arithmetic reference model.
module tb_seq_alu;
    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    seq_alu_if #(.OP_W(6), .DATA_W(16)) bus ();
    seq_alu #(.OP_W(6), .DATA_W(16)) dut (.clk(clk), .reset(reset), .bus(bus));

    int checks = 0;
    int errors = 0;
    logic [15:0] m_res = 16'h0000;
    logic [3:0]  m_flags = 4'h0;
    int          m_lat = 2;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the opcode's definition.
    function automatic void ref_model(input logic [5:0] op, input logic [15:0] a, input logic [15:0] b);
        int ua = int'(a);
        int ub = int'(b);
        int sa = int'($signed(a));
        int sb = int'($signed(b));
        int n  = int'(b[3:0]);
        int r  = 0;
        int s;
        longint p;
        bit c = 0, v = 0, upd = 1;
        logic [15:0] rr;
        m_lat = 2;
        case (int'(op[4:0]))
            11: begin r = ua + ub; c = (r > 65535); s = sa + sb; v = (s > 32767) || (s < -32768); end
            27: begin r = ua + 1;  c = (r > 65535); s = sa + 1;  v = (s > 32767); end
            12, 25: begin
                r = ua - ub; c = (ua >= ub); s = sa - sb; v = (s > 32767) || (s < -32768);
                if (op[4:0] == 5'd25) upd = 0;
            end
            28: begin r = ua - 1; c = (ua >= 1); s = sa - 1; v = (s < -32768); end
            13: begin r = ua >> n; c = (n != 0) ? ((ua >> (n - 1)) & 1) != 0 : 0; end
            14: begin r = ua << n; c = (n != 0) ? ((ua >> (16 - n)) & 1) != 0 : 0; end
            15: begin
                r = ua;
                for (int i = 0; i < n; i++) begin c = (r & 1) != 0; r = (r >> 1) | ((r & 1) << 15); end
            end
            16: begin
                r = ua;
                for (int i = 0; i < n; i++) begin c = ((r >> 15) & 1) != 0; r = ((r << 1) & 16'hFFFF) | int'(c); end
            end
            17: r = ub;
            18: begin p = longint'(ua) * longint'(ub); r = int'(p & 64'hFFFF); c = (p > 65535); m_lat = 18; end
            19: begin m_lat = 18; if (ub == 0) begin r = 16'hFFFF; v = 1; end else r = ua / ub; end
            20: begin m_lat = 18; if (ub == 0) begin r = ua; v = 1; end else r = ua % ub; end
            21: r = ua & ub;
            22: r = ua | ub;
            23: r = ua ^ ub;
            24: r = ~ua;
            26: begin r = ua & ub; upd = 0; end
            default: r = 0;
        endcase
        rr = 16'(r);
        m_flags = {(rr == 16'h0000), rr[15], c, v};
        if (upd) m_res = rr;
    endfunction

    task automatic run_op(input logic [5:0] op, input logic [15:0] a, input logic [15:0] b, input string tag);
        int cyc = 0;
        bit seen = 0;
        ref_model(op, a, b);
        @(negedge clk);
        bus.alu_start = 1'b1;
        bus.alu_operation = op;
        bus.op1 = a;
        bus.op2 = b;
        while (!seen && cyc < 40) begin
            @(posedge clk);
            #1;
            cyc++;
            if (cyc == 1) begin
                check({tag, " busy_after_accept"}, 32'(bus.alu_busy), 32'd1);
                bus.alu_operation = 6'($urandom);
                bus.op1 = 16'($urandom);
                bus.op2 = 16'($urandom);
            end
            if (bus.alu_done) seen = 1;
        end
        check({tag, " done_seen"}, 32'(seen), 32'd1);
        check({tag, " latency"}, 32'(cyc), 32'(m_lat));
        check({tag, " result"}, 32'(bus.alu_result), 32'(m_res));
        check({tag, " flags"}, 32'(bus.alu_flags), 32'(m_flags));
        check({tag, " busy_in_done"}, 32'(bus.alu_busy), 32'd1);
        @(posedge clk);
        #1;
        check({tag, " done_pulse"}, 32'(bus.alu_done), 32'd0);
        bus.alu_start = 1'b0;
        @(posedge clk);
        #1;
        check({tag, " no_retrigger"}, 32'({bus.alu_done, bus.alu_busy}), 32'd0);
        check({tag, " result_held"}, 32'(bus.alu_result), 32'(m_res));
    endtask

    logic [5:0]  rop;
    logic [15:0] ra, rb;

    initial begin
        bus.alu_start = 1'b0;
        bus.alu_operation = '0;
        bus.op1 = '0;
        bus.op2 = '0;
        #1;
        check("reset outputs", 32'({bus.alu_result, bus.alu_flags, bus.alu_done, bus.alu_busy}), 32'd0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("idle after release", 32'({bus.alu_done, bus.alu_busy}), 32'd0);

        run_op(6'd11, 16'h7FFF, 16'h0001, "add_ovf");
        run_op(6'd25, 16'h0005, 16'h0005, "cmp_eq");
        run_op(6'd18, 16'h0100, 16'h0100, "mul_wrap");
        run_op(6'd19, 16'h1234, 16'h0000, "div_zero");
        run_op(6'd20, 16'h0064, 16'h0007, "mod");
        run_op(6'd16, 16'h8001, 16'h0001, "rsl1");
        run_op(6'd14, 16'hA5A5, 16'h0010, "lsl0");
        run_op(6'd15, 16'h0003, 16'h0002, "rsr2");
        run_op(6'd13, 16'h8001, 16'h000F, "lsr15");
        run_op(6'd26, 16'h00F0, 16'h0F00, "tst_zero");
        run_op(6'd5,  16'h1111, 16'h2222, "illegal");
        run_op(6'd44, 16'h0003, 16'h0005, "imm_sub");
        run_op(6'd28, 16'h8000, 16'h0000, "dec_ovf");

        // Reset partway through a divide.
        @(negedge clk);
        bus.alu_start = 1'b1;
        bus.alu_operation = 6'd19;
        bus.op1 = 16'hBEEF;
        bus.op2 = 16'h0013;
        repeat (9) @(posedge clk);
        #2;
        check("pre_reset busy", 32'(bus.alu_busy), 32'd1);
        reset = 1'b0;
        #1;
        check("mid_div reset outputs", 32'({bus.alu_result, bus.alu_flags, bus.alu_done, bus.alu_busy}), 32'd0);
        bus.alu_start = 1'b0;
        m_res = 16'h0000;
        @(negedge clk);
        reset = 1'b1;
        repeat (20) @(negedge clk);
        check("no late div done", 32'({bus.alu_done, bus.alu_busy, bus.alu_result}), 32'd0);
        run_op(6'd11, 16'h1234, 16'h4321, "add_after_reset");

        for (int k = 0; k < 60; k++) begin
            rop = 6'($urandom_range(0, 63));
            ra  = 16'($urandom);
            rb  = 16'($urandom);
            if ($urandom_range(0, 3) == 0) rb = 16'($urandom_range(0, 3));
            run_op(rop, ra, rb, "rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
